// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid side plus the decode-facing
// valid/ready, redirect and halt signals. master = fetch unit, slave = memory/decode side.
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_halt;
    logic        o_halted;

    modport master (
        output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_halted,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready,
               i_redirect, i_redirect_pc, i_halt
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_halted,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_inst_ready,
               i_redirect, i_redirect_pc, i_halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, req/gnt memory issue, 2-entry instruction FIFO, redirect/halt.
// Optional FETCH_PERF_EN adds o_stall_cycles (saturating count of empty RUN cycles).
//
// state     | meaning
// ST_RUN    | fetching; requests issued while outstanding + buffered < 2
// ST_HALTED | ebreak seen; no requests, FIFO empty, responses discarded until reset
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  o_stall_cycles
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  drop_q, drop_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_inst_d [2];
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] tag_q [2];
    logic [31:0] tag_d [2];
    logic        tag_wr_q, tag_wr_d;
    logic        tag_rd_q, tag_rd_d;

    logic        run;
    logic        issue;
    logic        fire;
    logic        resp;
    logic        push;
    logic        pop;
    logic        unused_rpc_lsb;

    assign unused_rpc_lsb = ^bus.i_redirect_pc[1:0];

    always_comb begin
        run   = (state_q == ST_RUN);
        // Issue decision looks only at registered occupancy so req/addr stay stable until granted.
        issue = run && !i_rst && !bus.i_redirect && !bus.i_halt &&
                (({1'b0, out_q} + {1'b0, cnt_q}) < 3'd2);
        fire  = issue && bus.i_imem_gnt;
        resp  = bus.i_imem_rvalid;
        pop   = (cnt_q != 2'd0) && bus.i_inst_ready;
        push  = resp && run && (drop_q == 2'd0);

        state_d     = state_q;
        pc_d        = pc_q;
        out_d       = out_q + {1'b0, fire} - {1'b0, resp};
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;
        tag_d       = tag_q;
        tag_wr_d    = tag_wr_q;
        tag_rd_d    = tag_rd_q;

        if (fire) begin
            pc_d            = pc_q + 32'd4;
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = !tag_wr_q;
        end

        // Every response consumes its tag, dropped or not, so the tag queue stays aligned.
        if (resp) begin
            tag_rd_d = !tag_rd_q;
            if (drop_q != 2'd0) drop_d = drop_q - 2'd1;
        end

        if (push) begin
            fifo_inst_d[wr_ptr_q] = bus.i_imem_rdata;
            fifo_pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
            wr_ptr_d              = !wr_ptr_q;
        end
        if (pop) rd_ptr_d = !rd_ptr_q;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (run && bus.i_halt) begin
            state_d  = ST_HALTED;
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else if (run && bus.i_redirect) begin
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            drop_d   = out_q - {1'b0, resp};
            pc_d     = {bus.i_redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_ADDR;
            out_q       <= 2'd0;
            drop_q      <= 2'd0;
            cnt_q       <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fifo_inst_q <= '{default: '0};
            fifo_pc_q   <= '{default: '0};
            tag_q       <= '{default: '0};
            tag_wr_q    <= 1'b0;
            tag_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
            tag_q       <= tag_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
        end
    end

    assign bus.o_imem_req   = issue;
    assign bus.o_imem_addr  = pc_q;
    assign bus.o_inst_valid = (cnt_q != 2'd0);
    assign bus.o_inst       = fifo_inst_q[rd_ptr_q];
    assign bus.o_inst_pc    = fifo_pc_q[rd_ptr_q];
    assign bus.o_halted     = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (run && (cnt_q == 2'd0) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) stall_q <= 32'd0;
        else       stall_q <= stall_d;
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory latency/grant/ready/redirect
// against a PC-sequence reference model; perf counter checked when FETCH_PERF_EN is set.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    fetch_unit #(.RESET_ADDR(RST_PC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t memq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1, gnt_pct = 100;
    int delivered = 0;
    logic [31:0] exp_iss, exp_del;
    bit halted_m;
    logic c_req, c_gnt, c_rvalid, c_valid, c_ready, c_redir, c_halt, c_halted;
    logic [31:0] c_addr, c_inst, c_pc, c_rpc;
    logic p_req, p_gnt, p_redir;
    logic [31:0] p_addr;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic begin_cycle();
        @(negedge clk);
        bus.i_imem_gnt = ($urandom_range(99) < gnt_pct);
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            bus.i_imem_rvalid = 1'b1;
            bus.i_imem_rdata  = word_at(memq[0].a);
        end else begin
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_rdata  = $urandom;
        end
        bus.i_redirect = 1'b0;
        bus.i_halt     = 1'b0;
    endtask

    task automatic settle();
        #1;
        c_req = bus.o_imem_req;      c_addr = bus.o_imem_addr;   c_gnt = bus.i_imem_gnt;
        c_rvalid = bus.i_imem_rvalid; c_valid = bus.o_inst_valid; c_inst = bus.o_inst;
        c_pc = bus.o_inst_pc;        c_ready = bus.i_inst_ready; c_redir = bus.i_redirect;
        c_rpc = bus.i_redirect_pc;   c_halt = bus.i_halt;        c_halted = bus.o_halted;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        if (c_rvalid && memq.size() != 0) void'(memq.pop_front());
        if (c_req && c_gnt)
            memq.push_back('{a: c_addr, due: cyc + lat_min + int'($urandom_range(lat_max - lat_min))});
        if (c_valid && c_ready) begin exp_del += 32'd4; delivered++; end
        if (c_req && c_gnt) exp_iss += 32'd4;
        if (!halted_m && c_halt) halted_m = 1'b1;
        else if (!halted_m && c_redir) begin
            exp_iss = {c_rpc[31:2], 2'b00};
            exp_del = {c_rpc[31:2], 2'b00};
        end
        p_req = c_req; p_gnt = c_gnt; p_addr = c_addr; p_redir = c_redir && !halted_m;
        cyc++;
    endtask

    task automatic release_reset();
        memq.delete();
        exp_iss = RST_PC; exp_del = RST_PC; halted_m = 1'b0; delivered = 0;
        p_req = 1'b0; p_gnt = 1'b0; p_redir = 1'b0; p_addr = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic hold_reset_inputs();
        rst = 1'b1;
        bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
        bus.i_inst_ready = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = '0; bus.i_halt = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        hold_reset_inputs();
        #1;
        n_vec++; if (bus.o_imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.o_imem_req); end
        n_vec++; if (bus.o_imem_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr: got %h want %h", bus.o_imem_addr, RST_PC); end
        n_vec++; if (bus.o_inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.o_inst_valid); end
        n_vec++; if (bus.o_inst !== 32'd0) begin n_err++; $display("FAIL rst_inst: got %h want 0", bus.o_inst); end
        n_vec++; if (bus.o_inst_pc !== 32'd0) begin n_err++; $display("FAIL rst_pc: got %h want 0", bus.o_inst_pc); end
        n_vec++; if (bus.o_halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", bus.o_halted); end
`ifdef FETCH_PERF_EN
        n_vec++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
`endif
        release_reset();
        #1;
        n_vec++; if (bus.o_imem_req !== 1'b1) begin n_err++; $display("FAIL post_rst_req: got %b want 1", bus.o_imem_req); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        hold_reset_inputs();
        release_reset();
    endtask

    // Scenario 1: gnt=1, 1-cycle memory, ready=1 -> sequential addresses and PCs
    task automatic test_sequential();
        int n_iss = 0;
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        for (int i = 0; i < 40 && delivered < 8; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b1; settle();
            if (c_req) begin
                n_vec++; if (c_addr !== RST_PC + 32'(4 * n_iss)) begin n_err++;
                    $display("FAIL seq_addr: got %h want %h", c_addr, RST_PC + 32'(4 * n_iss)); end
                n_iss++;
            end
            if (c_valid) begin
                n_vec++; if (c_pc !== RST_PC + 32'(4 * delivered) || c_inst !== word_at(c_pc)) begin n_err++;
                    $display("FAIL seq_inst: got pc %h inst %h want pc %h", c_pc, c_inst, RST_PC + 32'(4 * delivered)); end
            end
            end_cycle();
        end
        n_vec++; if (delivered < 8) begin n_err++; $display("FAIL seq_count: got %0d want 8", delivered); end
    endtask

    // Scenario 2: ready low for 6 cycles, then release
    task automatic test_backpressure();
        logic held = 1'b0;
        logic [31:0] h_inst = '0, h_pc = '0;
        int d0;
        for (int i = 0; i < 6; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b0; settle();
            if (held) begin
                n_vec++; if (c_valid !== 1'b1 || c_inst !== h_inst || c_pc !== h_pc) begin n_err++;
                    $display("FAIL bp_hold: got v%b %h/%h want %h/%h", c_valid, c_inst, c_pc, h_inst, h_pc); end
            end else if (c_valid) begin
                held = 1'b1; h_inst = c_inst; h_pc = c_pc;
                n_vec++; if (c_pc !== exp_del) begin n_err++; $display("FAIL bp_head: got %h want %h", c_pc, exp_del); end
            end
            if (i == 5) begin
                n_vec++; if (c_req !== 1'b0) begin n_err++; $display("FAIL bp_req_drop: got %b want 0", c_req); end
            end
            end_cycle();
        end
        d0 = delivered;
        for (int i = 0; i < 12; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b1; settle();
            if (c_valid) begin
                n_vec++; if (c_pc !== exp_del || c_inst !== word_at(exp_del)) begin n_err++;
                    $display("FAIL bp_order: got %h/%h want pc %h", c_pc, c_inst, exp_del); end
            end
            end_cycle();
        end
        n_vec++; if (delivered - d0 < 6) begin n_err++; $display("FAIL bp_resume: got %0d want >=6", delivered - d0); end
    endtask

    // Scenario 3: gnt withheld with req pending
    task automatic test_gnt_hold();
        logic [31:0] h_addr = '0;
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            begin_cycle(); bus.i_imem_gnt = 1'b0; bus.i_inst_ready = 1'b1; settle();
            if (c_req) begin got = 1'b1; h_addr = c_addr; end
            end_cycle();
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL gh_req_timeout: got 0 want 1"); end
        for (int i = 0; i < 3; i++) begin
            begin_cycle(); bus.i_imem_gnt = (i == 2); bus.i_inst_ready = 1'b1; settle();
            n_vec++; if (c_req !== 1'b1 || c_addr !== h_addr) begin n_err++;
                $display("FAIL gh_stable: got %b/%h want 1/%h", c_req, c_addr, h_addr); end
            end_cycle();
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            begin_cycle(); bus.i_imem_gnt = 1'b0; bus.i_inst_ready = 1'b1; settle();
            if (c_req) begin
                got = 1'b1;
                n_vec++; if (c_addr !== h_addr + 32'd4) begin n_err++;
                    $display("FAIL gh_next: got %h want %h", c_addr, h_addr + 32'd4); end
            end
            end_cycle();
        end
    endtask

    // Scenario 4: 3-cycle memory, two in flight, redirect to 0x203
    task automatic test_redirect_drop();
        bit got = 1'b0;
        do_reset();
        lat_min = 3; lat_max = 3; gnt_pct = 100;
        for (int i = 0; i < 2; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b1; settle();
            n_vec++; if (c_req !== 1'b1 || c_addr !== RST_PC + 32'(4 * i)) begin n_err++;
                $display("FAIL rd_issue: got %b/%h want 1/%h", c_req, c_addr, RST_PC + 32'(4 * i)); end
            end_cycle();
        end
        begin_cycle(); bus.i_inst_ready = 1'b1;
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0203; settle();
        n_vec++; if (c_req !== 1'b0) begin n_err++; $display("FAIL rd_req_in_redirect: got %b want 0", c_req); end
        end_cycle();
        begin_cycle(); bus.i_inst_ready = 1'b1; settle();
        n_vec++; if (c_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush: got %b want 0", c_valid); end
        end_cycle();
        for (int i = 0; i < 20 && !got; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b1; settle();
            if (c_valid) begin
                got = 1'b1;
                n_vec++; if (c_pc !== 32'h0000_0200 || c_inst !== word_at(32'h0000_0200)) begin n_err++;
                    $display("FAIL rd_first: got %h/%h want pc 00000200", c_pc, c_inst); end
            end
            end_cycle();
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL rd_timeout: got 0 want 1"); end
    endtask

    task automatic test_random();
        int d0;
        do_reset();
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        for (int i = 0; i < 600; i++) begin
            begin_cycle();
            bus.i_inst_ready = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 4) begin
                bus.i_redirect = 1'b1; bus.i_redirect_pc = $urandom;
            end
            settle();
            if (c_req) begin
                n_vec++; if (c_addr !== exp_iss) begin n_err++; $display("FAIL rnd_addr: got %h want %h @%0d", c_addr, exp_iss, cyc); end
            end
            if (c_redir) begin
                n_vec++; if (c_req !== 1'b0) begin n_err++; $display("FAIL rnd_redir_req: got %b want 0 @%0d", c_req, cyc); end
            end else if (p_req && !p_gnt) begin
                n_vec++; if (c_req !== 1'b1 || c_addr !== p_addr) begin n_err++;
                    $display("FAIL rnd_stable: got %b/%h want 1/%h @%0d", c_req, c_addr, p_addr, cyc); end
            end
            if (memq.size() >= 2) begin
                n_vec++; if (c_req !== 1'b0) begin n_err++; $display("FAIL rnd_outstanding: got %b want 0 @%0d", c_req, cyc); end
            end
            if (p_redir) begin
                n_vec++; if (c_valid !== 1'b0) begin n_err++; $display("FAIL rnd_flush: got %b want 0 @%0d", c_valid, cyc); end
            end else if (c_valid) begin
                n_vec++; if (c_pc !== exp_del || c_inst !== word_at(exp_del)) begin n_err++;
                    $display("FAIL rnd_inst: got %h/%h want pc %h @%0d", c_pc, c_inst, exp_del, cyc); end
            end
            end_cycle();
        end
        d0 = delivered;
        n_vec++; if (d0 < 60) begin n_err++; $display("FAIL rnd_throughput: got %0d want >=60", d0); end
    endtask

    // Scenario 5: halt and redirect together
    task automatic test_halt();
        do_reset();
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        for (int i = 0; i < 6; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b1; settle(); end_cycle();
        end
        begin_cycle(); bus.i_inst_ready = 1'b1;
        bus.i_halt = 1'b1; bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0400; settle();
        n_vec++; if (c_req !== 1'b0) begin n_err++; $display("FAIL halt_req_same: got %b want 0", c_req); end
        end_cycle();
        for (int i = 0; i < 10; i++) begin
            begin_cycle(); bus.i_inst_ready = ($urandom_range(1) == 1); settle();
            n_vec++; if (c_halted !== 1'b1 || c_req !== 1'b0 || c_valid !== 1'b0) begin n_err++;
                $display("FAIL halt_state: got halted %b req %b valid %b want 1 0 0", c_halted, c_req, c_valid); end
            end_cycle();
        end
    endtask

`ifdef FETCH_PERF_EN
    // Scenario 6: stall counter against a count of empty RUN cycles
    task automatic test_perf();
        int ref_cnt = 0;
        do_reset();
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        for (int i = 0; i < 10; i++) begin
            begin_cycle(); bus.i_inst_ready = 1'b1; settle();
            if (!halted_m && !c_valid) ref_cnt++;
            end_cycle();
        end
        begin_cycle(); settle();
        n_vec++; if (stall_cycles !== 32'(ref_cnt)) begin n_err++;
            $display("FAIL perf_count: got %0d want %0d", stall_cycles, ref_cnt); end
        end_cycle();
        test_reset();
    endtask
`endif

    initial begin
        hold_reset_inputs();
        test_reset();
        test_sequential();
        test_backpressure();
        test_gnt_hold();
        test_redirect_drop();
        test_random();
        test_reset();
        test_halt();
        test_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
